// File: rtl/data_out_buffer_pkg.sv
// Shared definitions for the write-side output buffer: default sizes and FSM encodings.
package data_out_buffer_pkg;

    localparam int DEFAULT_WORD_SIZE = 16;
    localparam int DEFAULT_DEPTH     = 4;

    // Drain FSM: idle with nothing queued, or presenting the head entry to memory.
    typedef enum logic {
        OB_IDLE  = 1'b0,
        OB_WRITE = 1'b1
    } ob_state_e;

endpackage

// File: rtl/data_out_buffer_if.sv
// Bundle of the core write port, memory write port, forwarding port and status of the buffer.
// Handshakes:
//   core side  : a write is taken at a rising edge when wr_valid && wr_ready (wr_ready == !full).
//   memory side: mem_we holds with stable mem_addr/mem_data_out until an edge with mem_ack=1;
//                mem_ack is ignored while mem_we=0.
interface data_out_buffer_if #(
    parameter int W     = 16,
    parameter int LVL_W = 3
);
    logic             wr_valid;
    logic             wr_ready;
    logic [W-1:0]     wr_addr;
    logic [W-1:0]     wr_data;
    logic             mem_we;
    logic [W-1:0]     mem_addr;
    logic [W-1:0]     mem_data_out;
    logic             mem_ack;
    logic [W-1:0]     fwd_addr;
    logic             fwd_hit;
    logic [W-1:0]     fwd_data;
    logic             empty;
    logic [LVL_W-1:0] level;

    // Environment side: core, memory and read path.
    modport master (
        output wr_valid, wr_addr, wr_data, mem_ack, fwd_addr,
        input  wr_ready, mem_we, mem_addr, mem_data_out, fwd_hit, fwd_data, empty, level
    );

    // Buffer side.
    modport slave (
        input  wr_valid, wr_addr, wr_data, mem_ack, fwd_addr,
        output wr_ready, mem_we, mem_addr, mem_data_out, fwd_hit, fwd_data, empty, level
    );
endinterface

// File: rtl/data_out_buffer_fifo.sv
// Circular queue of (address, data) entries with per-entry valid bits exposed for forwarding.
module data_out_buffer_fifo
    import data_out_buffer_pkg::*;
#(
    parameter int W     = DEFAULT_WORD_SIZE,
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               wr_addr,
    input  logic [W-1:0]               wr_data,
    output logic [W-1:0]               head_addr,
    output logic [W-1:0]               head_data,
    output logic [PTR_W-1:0]           rd_ptr,
    output logic [DEPTH-1:0][W-1:0]    entry_addr,
    output logic [DEPTH-1:0][W-1:0]    entry_data,
    output logic [DEPTH-1:0]           entry_valid,
    output logic [LVL_W-1:0]           level,
    output logic [LVL_W-1:0]           level_next,
    output logic                       full,
    output logic                       empty
);
    logic [W-1:0]     addr_mem [DEPTH];
    logic [W-1:0]     data_mem [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Count after this edge; lets the drain FSM leave IDLE on the edge that fills an empty queue.
    always_comb begin
        level_next = level_q;
        case ({do_push, do_pop})
            2'b10:   level_next = level_q + 1'b1;
            2'b01:   level_next = level_q - 1'b1;
            default: level_next = level_q;
        endcase
    end

    // Pointers, occupancy and valid bits; a pushed slot is never the slot being popped.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            valid_q  <= '0;
        end else begin
            if (do_push) begin
                valid_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q          <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                valid_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q          <= rd_ptr_q + 1'b1;
            end
            level_q <= level_next;
        end
    end

    // Entry storage; contents are qualified by valid_q so it needs no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            addr_mem[wr_ptr_q] <= wr_addr;
            data_mem[wr_ptr_q] <= wr_data;
        end
    end

    // Flatten storage for the forward compare in the parent.
    always_comb begin
        entry_addr = '0;
        entry_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entry_addr[i] = addr_mem[i];
            entry_data[i] = data_mem[i];
        end
    end

    assign entry_valid = valid_q;
    assign head_addr   = addr_mem[rd_ptr_q];
    assign head_data   = data_mem[rd_ptr_q];
    assign rd_ptr      = rd_ptr_q;
    assign level       = level_q;
endmodule

// File: rtl/data_out_buffer.sv
// Queues subleq result writes and drains them in order to the memory write port,
// forwarding the youngest queued value of a matching address to the read path.
module data_out_buffer
    import data_out_buffer_pkg::*;
#(
    parameter int WORD_SIZE = DEFAULT_WORD_SIZE,
    parameter int DEPTH     = DEFAULT_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    data_out_buffer_if.slave     bus,
    output ob_state_e            state_dbg
);
    ob_state_e                      state_q;
    ob_state_e                      state_d;
    logic                           push;
    logic                           pop;
    logic [WORD_SIZE-1:0]           head_addr;
    logic [WORD_SIZE-1:0]           head_data;
    logic [PTR_W-1:0]               rd_ptr;
    logic [DEPTH-1:0][WORD_SIZE-1:0] entry_addr;
    logic [DEPTH-1:0][WORD_SIZE-1:0] entry_data;
    logic [DEPTH-1:0]               entry_valid;
    logic [LVL_W-1:0]               level;
    logic [LVL_W-1:0]               level_next;
    logic                           full;
    logic                           empty;
    logic [PTR_W-1:0]               idx;

    assign push = bus.wr_valid && !full;
    assign pop  = bus.mem_we && bus.mem_ack;

    data_out_buffer_fifo #(.W(WORD_SIZE), .DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .push        (push),
        .pop         (pop),
        .wr_addr     (bus.wr_addr),
        .wr_data     (bus.wr_data),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .rd_ptr      (rd_ptr),
        .entry_addr  (entry_addr),
        .entry_data  (entry_data),
        .entry_valid (entry_valid),
        .level       (level),
        .level_next  (level_next),
        .full        (full),
        .empty       (empty)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= OB_IDLE;
        else          state_q <= state_d;
    end

    // Next state: write whenever entries remain after this edge's push/pop.
    always_comb begin
        state_d = state_q;
        case (state_q)
            OB_IDLE:  state_d = (level_next != '0) ? OB_WRITE : OB_IDLE;
            OB_WRITE: state_d = (level_next != '0) ? OB_WRITE : OB_IDLE;
            default:  state_d = OB_IDLE;
        endcase
    end

    // Memory port: present the head while writing, zeros otherwise.
    always_comb begin
        bus.mem_we       = 1'b0;
        bus.mem_addr     = '0;
        bus.mem_data_out = '0;
        if (state_q == OB_WRITE) begin
            bus.mem_we       = 1'b1;
            bus.mem_addr     = head_addr;
            bus.mem_data_out = head_data;
        end
    end

    // Forward compare, scanned oldest to youngest so the youngest match overrides.
    always_comb begin
        bus.fwd_hit  = 1'b0;
        bus.fwd_data = '0;
        idx          = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PTR_W'(k);
            if (entry_valid[idx] && (entry_addr[idx] == bus.fwd_addr)) begin
                bus.fwd_hit  = 1'b1;
                bus.fwd_data = entry_data[idx];
            end
        end
    end

    assign bus.wr_ready = !full;
    assign bus.empty    = empty;
    assign bus.level    = level;
    assign state_dbg    = state_q;
endmodule

// File: tb/tb_data_out_buffer.sv
// Directed bench for data_out_buffer: reset, drain latency/handshake, full queue,
// forwarding priority, push+pop on one entry, mid-write reset and pointer wrap.
module tb_data_out_buffer;
    import data_out_buffer_pkg::*;

    logic      clk;
    logic      reset_n;
    ob_state_e state_dbg;
    int        vectors;
    int        miscompares;

    data_out_buffer_if #(.W(16), .LVL_W(3)) bus ();

    data_out_buffer #(.WORD_SIZE(16), .DEPTH(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_wr(input logic v, input logic [15:0] a, input logic [15:0] d);
        bus.wr_valid = v;
        bus.wr_addr  = a;
        bus.wr_data  = d;
    endtask

    // Directed stimulus and checks.
    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        set_wr(1'b0, 16'h0, 16'h0);
        bus.mem_ack  = 1'b0;
        bus.fwd_addr = 16'h0;
        tick();
        tick();
        reset_n = 1'b1;
        #1;

        // Reset state
        chk("rst_mem_we",   32'(bus.mem_we), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_mem_data", 32'(bus.mem_data_out), 32'd0);
        chk("rst_empty",    32'(bus.empty), 32'd1);
        chk("rst_wr_ready", 32'(bus.wr_ready), 32'd1);
        chk("rst_fwd_hit",  32'(bus.fwd_hit), 32'd0);
        chk("rst_level",    32'(bus.level), 32'd0);
        chk("rst_state",    32'(state_dbg), 32'(OB_IDLE));

        // 1: single write, ack held low 3 cycles
        set_wr(1'b1, 16'h0010, 16'h1234);
        tick();
        set_wr(1'b0, 16'h0, 16'h0);
        for (int c = 0; c < 3; c++) begin
            chk("t1_mem_we",   32'(bus.mem_we), 32'd1);
            chk("t1_mem_addr", 32'(bus.mem_addr), 32'h0010);
            chk("t1_mem_data", 32'(bus.mem_data_out), 32'h1234);
            chk("t1_level",    32'(bus.level), 32'd1);
            if (c < 2) tick();
        end
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        chk("t1_we_after_ack", 32'(bus.mem_we), 32'd0);
        chk("t1_empty",        32'(bus.empty), 32'd1);
        chk("t1_state",        32'(state_dbg), 32'(OB_IDLE));

        // 2: fill to 4, fifth push refused, then drain back-to-back
        for (int i = 0; i < 4; i++) begin
            set_wr(1'b1, 16'h0100 + 16'(i), 16'hA000 + 16'(i));
            tick();
        end
        chk("t2_level_full", 32'(bus.level), 32'd4);
        chk("t2_wr_ready",   32'(bus.wr_ready), 32'd0);
        set_wr(1'b1, 16'h01FF, 16'hDEAD);
        tick();
        set_wr(1'b0, 16'h0, 16'h0);
        chk("t2_level_5th",  32'(bus.level), 32'd4);
        bus.mem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t2_drain_we",   32'(bus.mem_we), 32'd1);
            chk("t2_drain_addr", 32'(bus.mem_addr), 32'h0100 + 32'(i));
            chk("t2_drain_data", 32'(bus.mem_data_out), 32'hA000 + 32'(i));
            tick();
        end
        bus.mem_ack = 1'b0;
        chk("t2_drained_we",    32'(bus.mem_we), 32'd0);
        chk("t2_drained_empty", 32'(bus.empty), 32'd1);

        // 3: forwarding picks the youngest match
        set_wr(1'b1, 16'h0020, 16'h0001);
        tick();
        set_wr(1'b1, 16'h0020, 16'h0002);
        tick();
        set_wr(1'b0, 16'h0, 16'h0);
        bus.fwd_addr = 16'h0020;
        #1;
        chk("t3_hit",      32'(bus.fwd_hit), 32'd1);
        chk("t3_data",     32'(bus.fwd_data), 32'h0002);
        bus.fwd_addr = 16'h0021;
        #1;
        chk("t3_miss_hit",  32'(bus.fwd_hit), 32'd0);
        chk("t3_miss_data", 32'(bus.fwd_data), 32'd0);
        bus.fwd_addr = 16'h0020;
        bus.mem_ack  = 1'b1;
        tick();
        chk("t3_pop1_hit",   32'(bus.fwd_hit), 32'd1);
        chk("t3_pop1_data",  32'(bus.fwd_data), 32'h0002);
        chk("t3_pop1_level", 32'(bus.level), 32'd1);
        tick();
        bus.mem_ack = 1'b0;
        chk("t3_pop2_hit",   32'(bus.fwd_hit), 32'd0);
        chk("t3_pop2_level", 32'(bus.level), 32'd0);

        // Same-cycle write data is not forwarded
        set_wr(1'b1, 16'h0030, 16'h3333);
        bus.fwd_addr = 16'h0030;
        #1;
        chk("nofwd_same_cycle", 32'(bus.fwd_hit), 32'd0);
        tick();
        chk("fwd_after_push", 32'(bus.fwd_data), 32'h3333);

        // 4: push and ack at the same edge on a one-entry queue
        set_wr(1'b1, 16'h0031, 16'h4444);
        bus.mem_ack = 1'b1;
        tick();
        set_wr(1'b0, 16'h0, 16'h0);
        bus.mem_ack = 1'b0;
        chk("t4_level",     32'(bus.level), 32'd1);
        chk("t4_mem_we",    32'(bus.mem_we), 32'd1);
        chk("t4_mem_addr",  32'(bus.mem_addr), 32'h0031);
        chk("t4_mem_data",  32'(bus.mem_data_out), 32'h4444);
        chk("t4_old_gone",  32'(bus.fwd_hit), 32'd0);

        // 5: reset while three writes are pending
        set_wr(1'b1, 16'h0040, 16'h5555);
        tick();
        set_wr(1'b1, 16'h0041, 16'h6666);
        tick();
        set_wr(1'b0, 16'h0, 16'h0);
        chk("t5_level3", 32'(bus.level), 32'd3);
        chk("t5_we",     32'(bus.mem_we), 32'd1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        bus.fwd_addr = 16'h0031;
        #1;
        chk("t5_rst_we",    32'(bus.mem_we), 32'd0);
        chk("t5_rst_level", 32'(bus.level), 32'd0);
        chk("t5_rst_empty", 32'(bus.empty), 32'd1);
        chk("t5_rst_fwd",   32'(bus.fwd_hit), 32'd0);
        tick();
        chk("t5_rst_we2",   32'(bus.mem_we), 32'd0);

        // 6: ten push/pop pairs wrap the pointers
        set_wr(1'b1, 16'h0200, 16'hB000);
        tick();
        for (int i = 1; i <= 10; i++) begin
            chk("t6_head_addr", 32'(bus.mem_addr), 32'h0200 + 32'(i - 1));
            chk("t6_head_data", 32'(bus.mem_data_out), 32'hB000 + 32'(i - 1));
            set_wr(1'b1, 16'h0200 + 16'(i), 16'hB000 + 16'(i));
            bus.mem_ack = 1'b1;
            tick();
            chk("t6_level", 32'(bus.level), 32'd1);
        end
        set_wr(1'b0, 16'h0, 16'h0);
        chk("t6_last_addr", 32'(bus.mem_addr), 32'h020A);
        chk("t6_last_data", 32'(bus.mem_data_out), 32'hB00A);
        tick();
        bus.mem_ack = 1'b0;
        chk("t6_empty", 32'(bus.empty), 32'd1);
        chk("t6_we",    32'(bus.mem_we), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
